mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have port: clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; forces reset state immediately.
REQ-003 SHALL have port: op  input  6  instruction[31:26] from the instruction register.
REQ-004 SHALL have port: funct  input  6  instruction[5:0].
REQ-005 SHALL have port: zero  input  1  ALU zero flag, valid in EXEC.
REQ-006 SHALL have outputs, each 1 bit: ir_write, pc_write, reg_write, mem_write, alu_src, if_extend.
REQ-007 SHALL have outputs reg_dst[1:0], memtoreg[1:0] and s_npc[1:0]. reg_dst: 0 = rt, 1 = rd, 2 = r31. memtoreg: 0 = pc+4, 1 = ALU, 2 = memory. s_npc: 0 = pc+4, 1 = branch, 2 = jump index, 3 = rs.
REQ-008 SHALL have outputs aluop[4:0] (0 = ADD, 1 = SUB, 2 = OR), state[2:0] and retired[31:0].

Function
REQ-009 SHALL implement an FSM with states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and HALT=5.
REQ-010 SHALL decode the following instructions:
- R-type (op 0): addu (funct 0x21), subu (0x23), jr (0x08)
- addiu 0x09, ori 0x0D, lw 0x23, sw 0x2B, beq 0x04, j 0x02, jal 0x03
REQ-011 SHALL, in FETCH, assert ir_write=1 and always go to DECODE.
REQ-012 SHALL, in DECODE for j, jal and jr, assert pc_write with s_npc 2/2/3 and return to FETCH; jal additionally asserts reg_write, reg_dst=2, memtoreg=0.
REQ-013 SHALL, in DECODE for all other legal opcodes, go to EXEC.
REQ-014 SHALL drive EXEC per opcode:
- addu/subu: alu_src=0, aluop ADD/SUB
- addiu/lw/sw: alu_src=1, if_extend=1, ADD
- ori: alu_src=1, if_extend=0, OR
- beq: alu_src=0, SUB, pc_write=1, s_npc=zero?1:0, then FETCH
REQ-015 SHALL go EXEC->MEM for lw/sw and EXEC->WB otherwise.
REQ-016 SHALL, in MEM for sw, assert mem_write, pc_write (s_npc=0) and return to FETCH; lw goes to WB.
REQ-017 SHALL, in WB, assert reg_write and pc_write (s_npc=0), then return to FETCH. reg_dst=1 for R-type, else 0. memtoreg=2 for lw, else 1.
REQ-018 SHALL give per-instruction latency in cycles: j/jal/jr 2, beq 3, R-type/addiu/ori/sw 4, lw 5.
REQ-019 SHALL assert pc_write exactly one cycle per instruction, always in its final state.
REQ-020 SHALL ensure reg_write and mem_write are never both 1, and are 0 in FETCH, EXEC and HALT.
REQ-021 SHALL increment retired by 1 on every clock edge where pc_write=1, wrapping from 0xFFFFFFFF to 0.
REQ-022 SHALL drive all outputs as combinational functions of state, op, funct and zero. Undriven controls are 0.
REQ-023 SHALL make state equal to the current FSM encoding.

Reset
REQ-024 SHALL, on reset, set the state to FETCH and retired to 0 asynchronously, including mid-instruction; the aborted instruction does not retire and no write is issued.
REQ-025 SHALL, while reset is high, hold all outputs at 0 except state=0.

Configuration
REQ-026 SHALL support the macro MC_CTRL_ILLEGAL_TRAP_EN.
- Defined: an unrecognised op/funct in DECODE enters HALT. HALT asserts no controls and stays until reset.
- Undefined: an unrecognised instruction is a NOP; DECODE asserts pc_write with s_npc=0 and goes to FETCH (2 cycles, retired increments). HALT is unreachable.

Verification
REQ-027 SHALL cover: reset, then addu (op 0, funct 0x21) -> states 0,1,2,4,0; reg_write=1 and reg_dst=1 only in WB; retired=1 after WB.
REQ-028 SHALL cover: lw (0x23) -> 5 cycles; memtoreg=2 in WB; sw (0x2B) -> mem_write=1 only in MEM, no reg_write; retired=2.
REQ-029 SHALL cover: beq with zero=1 -> s_npc=1 in EXEC; with zero=0 -> s_npc=0; both 3 cycles.
REQ-030 SHALL cover: jal (0x03) in DECODE -> reg_write=1, reg_dst=2, memtoreg=0, s_npc=2, pc_write=1.
REQ-031 SHALL cover: reset asserted during MEM of sw -> state=0 immediately, mem_write=0, retired=0.
REQ-032 SHALL cover: op 0x3F with the macro defined -> state=5, held for 10 cycles, retired unchanged; with the macro undefined -> 2-cycle NOP, retired+1.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Control bus between the instruction decoder context and the multicycle controller.
// The master drives the instruction fields and the zero flag; the slave drives the datapath controls.
interface mc_ctrl_if;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic        mem_write;
  logic        alu_src;
  logic        if_extend;
  logic [1:0]  reg_dst;
  logic [1:0]  memtoreg;
  logic [1:0]  s_npc;
  logic [4:0]  aluop;
  logic [2:0]  state;
  logic [31:0] retired;

  modport master (
    output op, funct, zero,
    input  ir_write, pc_write, reg_write, mem_write, alu_src, if_extend,
    input  reg_dst, memtoreg, s_npc, aluop, state, retired
  );

  modport slave (
    input  op, funct, zero,
    output ir_write, pc_write, reg_write, mem_write, alu_src, if_extend,
    output reg_dst, memtoreg, s_npc, aluop, state, retired
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset control FSM with a retired-instruction counter.
// Optional macro MC_CTRL_ILLEGAL_TRAP_EN: unrecognised instructions halt instead of acting as NOPs.
module mc_ctrl (
  input  logic      clock,
  input  logic      reset,
  mc_ctrl_if.slave  io_mc
);

  localparam int unsigned W_OP  = 6;
  localparam int unsigned W_SEL = 2;
  localparam int unsigned W_ALU = 5;
  localparam int unsigned W_ST  = 3;
  localparam int unsigned W_CNT = 32;

  typedef enum logic [W_ST-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_JR, I_ADDIU, I_ORI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_ILL
  } iclass_t;

  localparam logic [W_OP-1:0] OP_RTYPE = 6'h00;
  localparam logic [W_OP-1:0] OP_ADDIU = 6'h09;
  localparam logic [W_OP-1:0] OP_ORI   = 6'h0D;
  localparam logic [W_OP-1:0] OP_LW    = 6'h23;
  localparam logic [W_OP-1:0] OP_SW    = 6'h2B;
  localparam logic [W_OP-1:0] OP_BEQ   = 6'h04;
  localparam logic [W_OP-1:0] OP_J     = 6'h02;
  localparam logic [W_OP-1:0] OP_JAL   = 6'h03;

  localparam logic [W_OP-1:0] FN_ADDU  = 6'h21;
  localparam logic [W_OP-1:0] FN_SUBU  = 6'h23;
  localparam logic [W_OP-1:0] FN_JR    = 6'h08;

  localparam logic [W_SEL-1:0] RD_RT    = 2'd0;
  localparam logic [W_SEL-1:0] RD_RD    = 2'd1;
  localparam logic [W_SEL-1:0] RD_R31   = 2'd2;
  localparam logic [W_SEL-1:0] MTR_PC4  = 2'd0;
  localparam logic [W_SEL-1:0] MTR_ALU  = 2'd1;
  localparam logic [W_SEL-1:0] MTR_MEM  = 2'd2;
  localparam logic [W_SEL-1:0] NPC_PC4  = 2'd0;
  localparam logic [W_SEL-1:0] NPC_BR   = 2'd1;
  localparam logic [W_SEL-1:0] NPC_JUMP = 2'd2;
  localparam logic [W_SEL-1:0] NPC_RS   = 2'd3;

  localparam logic [W_ALU-1:0] ALU_ADD  = 5'd0;
  localparam logic [W_ALU-1:0] ALU_SUB  = 5'd1;
  localparam logic [W_ALU-1:0] ALU_OR   = 5'd2;

  state_t              r_state;
  state_t              w_next;
  iclass_t             w_iclass;
  logic [W_CNT-1:0]    r_retired;

  logic                w_ir_write;
  logic                w_pc_write;
  logic                w_reg_write;
  logic                w_mem_write;
  logic                w_alu_src;
  logic                w_if_extend;
  logic [W_SEL-1:0]    w_reg_dst;
  logic [W_SEL-1:0]    w_memtoreg;
  logic [W_SEL-1:0]    w_s_npc;
  logic [W_ALU-1:0]    w_aluop;

  // Instruction classification from the live op/funct fields.
  always_comb begin
    w_iclass = I_ILL;
    case (io_mc.op)
      OP_RTYPE: begin
        case (io_mc.funct)
          FN_ADDU: w_iclass = I_ADDU;
          FN_SUBU: w_iclass = I_SUBU;
          FN_JR:   w_iclass = I_JR;
          default: w_iclass = I_ILL;
        endcase
      end
      OP_ADDIU: w_iclass = I_ADDIU;
      OP_ORI:   w_iclass = I_ORI;
      OP_LW:    w_iclass = I_LW;
      OP_SW:    w_iclass = I_SW;
      OP_BEQ:   w_iclass = I_BEQ;
      OP_J:     w_iclass = I_J;
      OP_JAL:   w_iclass = I_JAL;
      default:  w_iclass = I_ILL;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        case (w_iclass)
          I_J, I_JAL, I_JR: w_next = S_FETCH;
          I_ILL: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            w_next = S_HALT;
`else
            w_next = S_FETCH;
`endif
          end
          default: w_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (w_iclass)
          I_LW, I_SW: w_next = S_MEM;
          I_BEQ:      w_next = S_FETCH;
          default:    w_next = S_WB;
        endcase
      end
      S_MEM:   w_next = (w_iclass == I_SW) ? S_FETCH : S_WB;
      S_WB:    w_next = S_FETCH;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  // Control outputs; all forced low while reset is held, including the FETCH ir_write.
  always_comb begin
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_reg_write = 1'b0;
    w_mem_write = 1'b0;
    w_alu_src   = 1'b0;
    w_if_extend = 1'b0;
    w_reg_dst   = RD_RT;
    w_memtoreg  = MTR_PC4;
    w_s_npc     = NPC_PC4;
    w_aluop     = ALU_ADD;
    if (!reset) begin
      case (r_state)
        S_FETCH: w_ir_write = 1'b1;
        S_DECODE: begin
          case (w_iclass)
            I_J: begin
              w_pc_write = 1'b1;
              w_s_npc    = NPC_JUMP;
            end
            I_JAL: begin
              w_pc_write  = 1'b1;
              w_s_npc     = NPC_JUMP;
              w_reg_write = 1'b1;
              w_reg_dst   = RD_R31;
              w_memtoreg  = MTR_PC4;
            end
            I_JR: begin
              w_pc_write = 1'b1;
              w_s_npc    = NPC_RS;
            end
            I_ILL: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
              w_pc_write = 1'b0;
`else
              w_pc_write = 1'b1;
`endif
              w_s_npc    = NPC_PC4;
            end
            default: ;
          endcase
        end
        S_EXEC: begin
          case (w_iclass)
            I_ADDU: w_aluop = ALU_ADD;
            I_SUBU: w_aluop = ALU_SUB;
            I_ADDIU, I_LW, I_SW: begin
              w_alu_src   = 1'b1;
              w_if_extend = 1'b1;
              w_aluop     = ALU_ADD;
            end
            I_ORI: begin
              w_alu_src = 1'b1;
              w_aluop   = ALU_OR;
            end
            I_BEQ: begin
              w_aluop    = ALU_SUB;
              w_pc_write = 1'b1;
              w_s_npc    = io_mc.zero ? NPC_BR : NPC_PC4;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          if (w_iclass == I_SW) begin
            w_mem_write = 1'b1;
            w_pc_write  = 1'b1;
          end
        end
        S_WB: begin
          w_reg_write = 1'b1;
          w_pc_write  = 1'b1;
          w_reg_dst   = (io_mc.op == OP_RTYPE) ? RD_RD : RD_RT;
          w_memtoreg  = (w_iclass == I_LW) ? MTR_MEM : MTR_ALU;
        end
        default: ;
      endcase
    end
  end

  // Retired count: one per pc_write cycle, wraps naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_retired <= '0;
    end else if (w_pc_write) begin
      r_retired <= r_retired + W_CNT'(1);
    end
  end

  assign io_mc.ir_write  = w_ir_write;
  assign io_mc.pc_write  = w_pc_write;
  assign io_mc.reg_write = w_reg_write;
  assign io_mc.mem_write = w_mem_write;
  assign io_mc.alu_src   = w_alu_src;
  assign io_mc.if_extend = w_if_extend;
  assign io_mc.reg_dst   = w_reg_dst;
  assign io_mc.memtoreg  = w_memtoreg;
  assign io_mc.s_npc     = w_s_npc;
  assign io_mc.aluop     = w_aluop;
  assign io_mc.state     = W_ST'(r_state);
  assign io_mc.retired   = r_retired;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: steps instructions through the FSM and checks every control per state.
module tb_mc_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  mc_ctrl_if bus ();

  mc_ctrl u_dut (
    .clock (clock),
    .reset (reset),
    .io_mc (bus)
  );

  always #5 clock = ~clock;

  // Packs expected controls: {ir,pc,rw,mw,as,ie,reg_dst,memtoreg,s_npc,aluop,state}.
  function automatic logic [31:0] ctl(input bit ir, input bit pc, input bit rw, input bit mw,
                                      input bit as, input bit ie, input logic [1:0] rd,
                                      input logic [1:0] mt, input logic [1:0] sn,
                                      input logic [4:0] alu, input logic [2:0] st);
    return {12'd0, ir, pc, rw, mw, as, ie, rd, mt, sn, alu, st};
  endfunction

  function automatic logic [31:0] obs_ctl();
    return {12'd0, bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write, bus.alu_src,
            bus.if_extend, bus.reg_dst, bus.memtoreg, bus.s_npc, bus.aluop, bus.state};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    bus.op    = op;
    bus.funct = fn;
    bus.zero  = z;
    #1;
  endtask

  initial begin
    bus.op = 6'h00; bus.funct = 6'h21; bus.zero = 1'b0;

    // Reset held: everything 0 including ir_write.
    #12;
    chk("rst_ctl", obs_ctl(), ctl(0,0,0,0,0,0,0,0,0,0,0));
    chk("rst_ret", bus.retired, 32'd0);
    tick();
    chk("rst_ctl_hold", obs_ctl(), ctl(0,0,0,0,0,0,0,0,0,0,0));
    reset = 1'b0;
    #1;

    // addu: 0,1,2,4,0
    chk("addu_f", obs_ctl(), ctl(1,0,0,0,0,0,0,0,0,0,0));
    tick(); chk("addu_d", obs_ctl(), ctl(0,0,0,0,0,0,0,0,0,0,1));
    tick(); chk("addu_e", obs_ctl(), ctl(0,0,0,0,0,0,0,0,0,0,2));
    tick(); chk("addu_wb", obs_ctl(), ctl(0,1,1,0,0,0,1,1,0,0,4));
    chk("addu_ret_pre", bus.retired, 32'd0);
    tick(); chk("addu_back", obs_ctl(), ctl(1,0,0,0,0,0,0,0,0,0,0));
    chk("addu_ret", bus.retired, 32'd1);

    // subu
    set_instr(6'h00, 6'h23, 1'b0);
    tick(); tick(); chk("subu_e", obs_ctl(), ctl(0,0,0,0,0,0,0,0,0,1,2));
    tick(); chk("subu_wb", obs_ctl(), ctl(0,1,1,0,0,0,1,1,0,0,4));
    tick(); chk("subu_ret", bus.retired, 32'd2);

    // lw: 5 cycles
    set_instr(6'h23, 6'h00, 1'b0);
    tick(); chk("lw_d", obs_ctl(), ctl(0,0,0,0,0,0,0,0,0,0,1));
    tick(); chk("lw_e", obs_ctl(), ctl(0,0,0,0,1,1,0,0,0,0,2));
    tick(); chk("lw_mem", obs_ctl(), ctl(0,0,0,0,0,0,0,0,0,0,3));
    tick(); chk("lw_wb", obs_ctl(), ctl(0,1,1,0,0,0,0,2,0,0,4));
    tick(); chk("lw_f", obs_ctl(), ctl(1,0,0,0,0,0,0,0,0,0,0));
    chk("lw_ret", bus.retired, 32'd3);

    // sw: 4 cycles, mem_write only in MEM
    set_instr(6'h2B, 6'h00, 1'b0);
    tick(); tick(); chk("sw_e", obs_ctl(), ctl(0,0,0,0,1,1,0,0,0,0,2));
    tick(); chk("sw_mem", obs_ctl(), ctl(0,1,0,1,0,0,0,0,0,0,3));
    tick(); chk("sw_f", obs_ctl(), ctl(1,0,0,0,0,0,0,0,0,0,0));
    chk("sw_ret", bus.retired, 32'd4);

    // beq taken / not taken: 3 cycles
    set_instr(6'h04, 6'h00, 1'b1);
    tick(); tick(); chk("beq_t_e", obs_ctl(), ctl(0,1,0,0,0,0,0,0,1,1,2));
    tick(); chk("beq_t_f", obs_ctl(), ctl(1,0,0,0,0,0,0,0,0,0,0));
    set_instr(6'h04, 6'h00, 1'b0);
    tick(); tick(); chk("beq_n_e", obs_ctl(), ctl(0,1,0,0,0,0,0,0,0,1,2));
    tick(); chk("beq_n_f", obs_ctl(), ctl(1,0,0,0,0,0,0,0,0,0,0));
    chk("beq_ret", bus.retired, 32'd6);

    // jal, j, jr: 2 cycles each
    set_instr(6'h03, 6'h00, 1'b0);
    tick(); chk("jal_d", obs_ctl(), ctl(0,1,1,0,0,0,2,0,2,0,1));
    tick(); chk("jal_f", obs_ctl(), ctl(1,0,0,0,0,0,0,0,0,0,0));
    set_instr(6'h02, 6'h00, 1'b0);
    tick(); chk("j_d", obs_ctl(), ctl(0,1,0,0,0,0,0,0,2,0,1));
    set_instr(6'h00, 6'h08, 1'b0);
    tick(); tick(); chk("jr_d", obs_ctl(), ctl(0,1,0,0,0,0,0,0,3,0,1));
    tick(); chk("jr_ret", bus.retired, 32'd9);

    // addiu and ori go through WB with reg_dst=rt, memtoreg=ALU
    set_instr(6'h09, 6'h00, 1'b0);
    tick(); tick(); chk("addiu_e", obs_ctl(), ctl(0,0,0,0,1,1,0,0,0,0,2));
    tick(); chk("addiu_wb", obs_ctl(), ctl(0,1,1,0,0,0,0,1,0,0,4));
    set_instr(6'h0D, 6'h00, 1'b0);
    tick(); tick(); tick(); chk("ori_e", obs_ctl(), ctl(0,0,0,0,1,0,0,0,0,2,2));
    tick(); chk("ori_wb", obs_ctl(), ctl(0,1,1,0,0,0,0,1,0,0,4));
    tick(); chk("ori_ret", bus.retired, 32'd11);

    // Reset during MEM of sw aborts without retiring
    set_instr(6'h2B, 6'h00, 1'b0);
    tick(); tick(); tick();
    chk("abort_mem", obs_ctl(), ctl(0,1,0,1,0,0,0,0,0,0,3));
    reset = 1'b1;
    #1;
    chk("abort_ctl", obs_ctl(), ctl(0,0,0,0,0,0,0,0,0,0,0));
    chk("abort_ret", bus.retired, 32'd0);
    tick();
    chk("abort_ret_hold", bus.retired, 32'd0);
    reset = 1'b0;
    #1;
    chk("abort_f", obs_ctl(), ctl(1,0,0,0,0,0,0,0,0,0,0));

    // Illegal opcode 0x3F
    set_instr(6'h3F, 6'h00, 1'b0);
    tick();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    chk("ill_d", obs_ctl(), ctl(0,0,0,0,0,0,0,0,0,0,1));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("ill_halt", obs_ctl(), ctl(0,0,0,0,0,0,0,0,0,0,5));
    end
    chk("ill_ret", bus.retired, 32'd0);
`else
    chk("ill_d", obs_ctl(), ctl(0,1,0,0,0,0,0,0,0,0,1));
    tick();
    chk("ill_f", obs_ctl(), ctl(1,0,0,0,0,0,0,0,0,0,0));
    chk("ill_ret", bus.retired, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
